// File: rtl/calc_sequence_controller_pkg.sv
// Shared types and constants for the calculator sequence controller:
// FSM state encoding, data widths, default error answer and LED decode.
package calc_seq_pkg;

   localparam int NUM_W = 16;
   localparam int OP_W  = 3;
   localparam int ANS_W = 32;

   localparam logic [ANS_W-1:0] ERROR_ANSWER_DEFAULT = 32'hEEEE_EEEE;

   typedef enum logic [2:0] {
      ST_ENTER_NUM1 = 3'd0,
      ST_ENTER_NUM2 = 3'd1,
      ST_ENTER_OP   = 3'd2,
      ST_LAUNCH     = 3'd3,
      ST_WAIT       = 3'd4,
      ST_SHOW       = 3'd5
   } state_t;

   // One-hot {num1, num2, op} entry indicator; dark outside the entry stages.
   function automatic logic [2:0] stage_leds_f(input state_t st);
      logic [2:0] leds;
      case (st)
         ST_ENTER_NUM1: leds = 3'b100;
         ST_ENTER_NUM2: leds = 3'b010;
         ST_ENTER_OP:   leds = 3'b001;
         default:       leds = 3'b000;
      endcase
      return leds;
   endfunction

endpackage

// File: rtl/calc_sequence_controller_if.sv
// ALU launch/completion handshake between the sequence controller and the ALU.
interface calc_sequence_controller_if;
   import calc_seq_pkg::*;

   logic             start;
   logic             done;
   logic [ANS_W-1:0] result;
   logic             error;

   modport master (output start, input done, input result, input error);
   modport slave  (input start, output done, output result, output error);

endinterface

// File: rtl/calc_button_edge.sv
// Rising-edge detector for a debounced button level. A button already held
// when reset releases is suppressed until it is seen low at least once.
module calc_button_edge (
   input  logic clk,
   input  logic reset_n,
   input  logic button,
   output logic rise
);

   logic hist_r;
   logic armed_r;

   // History of the button level and a one-cycle post-reset arming flag.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         hist_r  <= 1'b0;
         armed_r <= 1'b0;
      end else begin
         hist_r  <= button;
         armed_r <= 1'b1;
      end
   end

   assign rise = button & ~hist_r & armed_r;

endmodule

// File: rtl/calc_sequence_controller.sv
// Operand/op-code entry sequencer that launches the ALU and latches its answer.
// Define CALC_SEQ_TIMEOUT_EN to abort a WAIT after TIMEOUT_CYCLES cycles.
module calc_sequence_controller
   import calc_seq_pkg::*;
#(
   parameter int unsigned      TIMEOUT_CYCLES = 1024,
   parameter logic [ANS_W-1:0] ERROR_ANSWER   = ERROR_ANSWER_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 next_button,
   input  logic                 prev_button,
   input  logic [NUM_W-1:0]     switches,
   calc_sequence_controller_if.master alu,
   output logic [NUM_W-1:0]     num1,
   output logic [NUM_W-1:0]     num2,
   output logic [OP_W-1:0]      operation_code,
   output logic [ANS_W-1:0]     answer,
   output logic                 show_16bit_input,
   output logic                 show_operation,
   output logic                 show_answer,
   output logic [2:0]           stage_leds,
   output logic                 busy,
   output logic                 error
);

   if (TIMEOUT_CYCLES < 2) begin : g_timeout_range
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   state_t state_r, next_state_s;
   logic   next_edge_s, prev_edge_s, nxt_s, prv_s, timeout_s;

   logic [NUM_W-1:0] num1_r, num1_s, num2_r, num2_s;
   logic [OP_W-1:0]  op_r, op_s;
   logic [ANS_W-1:0] answer_r, answer_s;
   logic             error_r, error_s, start_r, start_s, busy_r, busy_s;
   logic             show_in_r, show_in_s, show_op_r, show_op_s, show_ans_r, show_ans_s;
   logic [2:0]       leds_r, leds_s;

   calc_button_edge u_next_edge (.clk(clk), .reset_n(reset_n), .button(next_button), .rise(next_edge_s));
   calc_button_edge u_prev_edge (.clk(clk), .reset_n(reset_n), .button(prev_button), .rise(prev_edge_s));

   // Simultaneous next/prev edges cancel each other out.
   assign nxt_s = next_edge_s & ~prev_edge_s;
   assign prv_s = prev_edge_s & ~next_edge_s;

`ifdef CALC_SEQ_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0] wait_cnt_r;

   // Cycles spent in WAIT; restarts on every entry.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wait_cnt_r <= {CNT_W{1'b0}};
      end else if (state_r == ST_WAIT) begin
         wait_cnt_r <= wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         wait_cnt_r <= {CNT_W{1'b0}};
      end
   end

   assign timeout_s = (state_r == ST_WAIT) && (wait_cnt_r == CNT_LAST);
`else
   assign timeout_s = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r <= ST_ENTER_NUM1;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state decode.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_ENTER_NUM1: if (nxt_s) next_state_s = ST_ENTER_NUM2; else next_state_s = state_r;
         ST_ENTER_NUM2: if (nxt_s) next_state_s = ST_ENTER_OP;
                        else if (prv_s) next_state_s = ST_ENTER_NUM1;
                        else next_state_s = state_r;
         ST_ENTER_OP:   if (nxt_s) next_state_s = ST_LAUNCH;
                        else if (prv_s) next_state_s = ST_ENTER_NUM2;
                        else next_state_s = state_r;
         ST_LAUNCH:     next_state_s = ST_WAIT;
         ST_WAIT:       if (alu.done || timeout_s) next_state_s = ST_SHOW; else next_state_s = state_r;
         ST_SHOW:       if (nxt_s) next_state_s = ST_ENTER_NUM1;
                        else if (prv_s) next_state_s = ST_ENTER_OP;
                        else next_state_s = state_r;
         default:       next_state_s = ST_ENTER_NUM1;
      endcase
   end

   // Next values of every registered output; display decode follows the next state.
   always_comb begin
      num1_s   = num1_r;
      num2_s   = num2_r;
      op_s     = op_r;
      answer_s = answer_r;
      error_s  = error_r;
      case (state_r)
         ST_ENTER_NUM1: if (nxt_s) num1_s = switches; else num1_s = num1_r;
         ST_ENTER_NUM2: if (nxt_s) num2_s = switches; else num2_s = num2_r;
         ST_ENTER_OP:   if (nxt_s) op_s = switches[OP_W-1:0]; else op_s = op_r;
         ST_WAIT: begin
            if (alu.done) begin
               answer_s = alu.error ? ERROR_ANSWER : alu.result;
               error_s  = alu.error;
            end else if (timeout_s) begin
               answer_s = ERROR_ANSWER;
               error_s  = 1'b1;
            end else begin
               answer_s = answer_r;
            end
         end
         ST_SHOW:       if (nxt_s) error_s = 1'b0; else error_s = error_r;
         default:       num1_s = num1_r;
      endcase
      start_s    = (next_state_s == ST_LAUNCH);
      busy_s     = (next_state_s == ST_LAUNCH) || (next_state_s == ST_WAIT);
      leds_s     = stage_leds_f(next_state_s);
      show_in_s  = (next_state_s == ST_ENTER_NUM1) || (next_state_s == ST_ENTER_NUM2);
      show_op_s  = (next_state_s == ST_ENTER_OP);
      show_ans_s = ~(show_in_s | show_op_s);
   end

   // Output registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         num1_r     <= 16'h0000;
         num2_r     <= 16'h0000;
         op_r       <= 3'b000;
         answer_r   <= 32'h0000_0000;
         error_r    <= 1'b0;
         start_r    <= 1'b0;
         busy_r     <= 1'b0;
         leds_r     <= 3'b100;
         show_in_r  <= 1'b1;
         show_op_r  <= 1'b0;
         show_ans_r <= 1'b0;
      end else begin
         num1_r     <= num1_s;
         num2_r     <= num2_s;
         op_r       <= op_s;
         answer_r   <= answer_s;
         error_r    <= error_s;
         start_r    <= start_s;
         busy_r     <= busy_s;
         leds_r     <= leds_s;
         show_in_r  <= show_in_s;
         show_op_r  <= show_op_s;
         show_ans_r <= show_ans_s;
      end
   end

   assign num1             = num1_r;
   assign num2             = num2_r;
   assign operation_code   = op_r;
   assign answer           = answer_r;
   assign error            = error_r;
   assign alu.start        = start_r;
   assign busy             = busy_r;
   assign stage_leds       = leds_r;
   assign show_16bit_input = show_in_r;
   assign show_operation   = show_op_r;
   assign show_answer      = show_ans_r;

endmodule

// File: tb/tb_calc_sequence_controller.sv
// Directed self-checking bench for calc_sequence_controller.
module tb_calc_sequence_controller;
   import calc_seq_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n, next_button, prev_button;
   logic [15:0] switches;
   logic [15:0] num1, num2;
   logic [2:0]  operation_code, stage_leds;
   logic [31:0] answer;
   logic        show_16bit_input, show_operation, show_answer, busy, error;
   int          n_checks = 0;
   int          n_errors = 0;

   always #5 clk = ~clk;

   calc_sequence_controller_if alu_if ();

   calc_sequence_controller #(.TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .reset_n(reset_n), .next_button(next_button), .prev_button(prev_button),
      .switches(switches), .alu(alu_if), .num1(num1), .num2(num2),
      .operation_code(operation_code), .answer(answer), .show_16bit_input(show_16bit_input),
      .show_operation(show_operation), .show_answer(show_answer), .stage_leds(stage_leds),
      .busy(busy), .error(error)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic press_next(input logic [15:0] sw);
      switches = sw; next_button = 1'b1; step();
      next_button = 1'b0; step();
   endtask

   task automatic press_prev();
      prev_button = 1'b1; step();
      prev_button = 1'b0; step();
   endtask

   task automatic check_reset_state(input string tag);
      n_checks++;
      if ({num1, num2, operation_code, answer} !== 67'h0) begin
         n_errors++; $display("FAIL %s_data got %h %h %h %h need 0", tag, num1, num2, operation_code, answer);
      end
      n_checks++;
      if ({stage_leds, show_16bit_input, show_operation, show_answer} !== 6'b100_100) begin
         n_errors++; $display("FAIL %s_display got %b need 100100", tag, {stage_leds, show_16bit_input, show_operation, show_answer});
      end
      n_checks++;
      if ({alu_if.start, busy, error} !== 3'b000) begin
         n_errors++; $display("FAIL %s_ctrl got %b need 000", tag, {alu_if.start, busy, error});
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; next_button = 1'b1; prev_button = 1'b0; switches = 16'h0000;
      alu_if.done = 1'b0; alu_if.error = 1'b0; alu_if.result = 32'h0;
      step(); step();
      check_reset_state("reset");
      reset_n = 1'b1; step(); step();
      n_checks++;
      if (stage_leds !== 3'b100) begin
         n_errors++; $display("FAIL held_through_reset got %b need 100", stage_leds);
      end
      next_button = 1'b0; step();
   endtask

   task automatic test_entry();
      press_next(16'h0012);
      n_checks++;
      if ({num1, stage_leds} !== {16'h0012, 3'b010}) begin
         n_errors++; $display("FAIL num1_latch got %h %b need 0012 010", num1, stage_leds);
      end
      press_next(16'h0034);
      n_checks++;
      if ({num2, stage_leds, show_operation} !== {16'h0034, 3'b001, 1'b1}) begin
         n_errors++; $display("FAIL num2_latch got %h %b %b need 0034 001 1", num2, stage_leds, show_operation);
      end
      switches = 16'h0002; next_button = 1'b1; step();
      n_checks++;
      if ({alu_if.start, busy, operation_code, show_answer, stage_leds} !== {1'b1, 1'b1, 3'd2, 1'b1, 3'b000}) begin
         n_errors++; $display("FAIL launch got start=%b busy=%b op=%0d ans=%b leds=%b", alu_if.start, busy, operation_code, show_answer, stage_leds);
      end
      next_button = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         n_checks++;
         if ({alu_if.start, busy} !== 2'b01) begin
            n_errors++; $display("FAIL single_start cyc%0d got start=%b busy=%b need 0 1", i, alu_if.start, busy);
         end
      end
      alu_if.done = 1'b1; alu_if.result = 32'h0000_0046; step();
      alu_if.done = 1'b0;
      n_checks++;
      if ({answer, show_answer, busy, error, stage_leds} !== {32'h0000_0046, 1'b1, 1'b0, 1'b0, 3'b000}) begin
         n_errors++; $display("FAIL done_answer got %h ans=%b busy=%b err=%b", answer, show_answer, busy, error);
      end
   endtask

   task automatic test_prev();
      press_prev();
      n_checks++;
      if ({stage_leds, show_operation, answer} !== {3'b001, 1'b1, 32'h0000_0046}) begin
         n_errors++; $display("FAIL show_prev got %b %b %h need 001 1 00000046", stage_leds, show_operation, answer);
      end
      press_prev();
      n_checks++;
      if (stage_leds !== 3'b010) begin
         n_errors++; $display("FAIL op_prev got %b need 010", stage_leds);
      end
      press_prev(); press_prev();
      n_checks++;
      if ({stage_leds, num1, num2} !== {3'b100, 16'h0012, 16'h0034}) begin
         n_errors++; $display("FAIL num1_prev got %b %h %h need 100 0012 0034", stage_leds, num1, num2);
      end
   endtask

   task automatic test_same_cycle_and_hold();
      press_next(16'h0056);
      next_button = 1'b1; prev_button = 1'b1; step();
      next_button = 1'b0; prev_button = 1'b0; step();
      n_checks++;
      if (stage_leds !== 3'b010) begin
         n_errors++; $display("FAIL both_edges got %b need 010", stage_leds);
      end
      switches = 16'h0078; next_button = 1'b1;
      repeat (20) step();
      next_button = 1'b0; step();
      n_checks++;
      if ({stage_leds, num2, busy} !== {3'b001, 16'h0078, 1'b0}) begin
         n_errors++; $display("FAIL held_next got %b %h busy=%b need 001 0078 0", stage_leds, num2, busy);
      end
   endtask

   task automatic test_alu_error();
      press_next(16'h0003);
      alu_if.done = 1'b1; alu_if.error = 1'b1; alu_if.result = 32'h0000_1234; step();
      alu_if.done = 1'b0; alu_if.error = 1'b0;
      n_checks++;
      if ({answer, error, show_answer} !== {32'hEEEE_EEEE, 1'b1, 1'b1}) begin
         n_errors++; $display("FAIL alu_error got %h err=%b need EEEEEEEE 1", answer, error);
      end
      press_next(16'h0000);
      n_checks++;
      if ({stage_leds, error, show_16bit_input} !== {3'b100, 1'b0, 1'b1}) begin
         n_errors++; $display("FAIL error_clear got %b err=%b need 100 0", stage_leds, error);
      end
   endtask

   task automatic test_wait_policy();
      int k;
      press_next(16'h0001); press_next(16'h0002);
      switches = 16'h0000; next_button = 1'b1; step();
      alu_if.done = 1'b1; alu_if.result = 32'h0000_0099; next_button = 1'b0; step();
      alu_if.done = 1'b0;
      n_checks++;
      if ({busy, answer} !== {1'b1, 32'hEEEE_EEEE}) begin
         n_errors++; $display("FAIL done_in_launch got busy=%b %h need 1 EEEEEEEE", busy, answer);
      end
`ifdef CALC_SEQ_TIMEOUT_EN
      k = 0;
      while (busy === 1'b1 && k < 50) begin
         step(); k++;
      end
      n_checks++;
      if ({k, error, answer} !== {32'd8, 1'b1, 32'hEEEE_EEEE}) begin
         n_errors++; $display("FAIL timeout got cycles=%0d err=%b %h need 8 1 EEEEEEEE", k, error, answer);
      end
      alu_if.done = 1'b1; alu_if.result = 32'h0000_0077; step();
      alu_if.done = 1'b0;
      n_checks++;
      if ({answer, error} !== {32'hEEEE_EEEE, 1'b1}) begin
         n_errors++; $display("FAIL late_done got %h err=%b need EEEEEEEE 1", answer, error);
      end
`else
      k = 0;
      repeat (40) step();
      n_checks++;
      if ({busy, show_answer, k} !== {1'b1, 1'b1, 32'd0}) begin
         n_errors++; $display("FAIL wait_persist got busy=%b ans=%b need 1 1", busy, show_answer);
      end
      alu_if.done = 1'b1; alu_if.result = 32'hCAFE_0001; step();
      alu_if.done = 1'b0;
      n_checks++;
      if ({answer, error, busy} !== {32'hCAFE_0001, 1'b0, 1'b0}) begin
         n_errors++; $display("FAIL late_result got %h err=%b busy=%b need CAFE0001 0 0", answer, error, busy);
      end
`endif
      press_next(16'h0000);
   endtask

   task automatic test_reset_in_wait();
      press_next(16'h0005); press_next(16'h0006); press_next(16'h0001);
      n_checks++;
      if (busy !== 1'b1) begin
         n_errors++; $display("FAIL reach_wait got busy=%b need 1", busy);
      end
      reset_n = 1'b0; step();
      check_reset_state("wait_reset");
      reset_n = 1'b1; alu_if.done = 1'b1; alu_if.result = 32'h0000_0055; step();
      alu_if.done = 1'b0;
      n_checks++;
      if ({answer, stage_leds, busy} !== {32'h0, 3'b100, 1'b0}) begin
         n_errors++; $display("FAIL done_after_reset got %h %b busy=%b need 0 100 0", answer, stage_leds, busy);
      end
   endtask

   initial begin
      test_reset();
      test_entry();
      test_prev();
      test_same_cycle_and_hold();
      test_alu_error();
      test_wait_policy();
      test_reset_in_wait();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
